commit_trace_gen: RTL and testbench

Producer side of the difftest commit path inside the CPU. Accepts retirement events from the writeback stage, buffers them in a small FIFO, maintains a shadow GPR file, and presents one committed instruction per cycle to the difftest commit and memory-trace sinks. Halts the stream after the ebreak commit.

---
 rtl/commit_trace_gen.sv | 277 +++++++++++++++++++++++++++
 tb/tb_commit_trace_gen.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_trace_gen.sv
// commit_trace_gen
//
// Producer side of the difftest commit path. Retirement events from the
// writeback stage are buffered in a DEPTH-entry FIFO and drained one per
// cycle toward the difftest commit / memory-trace sinks. A shadow GPR file
// is kept in step with the drained stream, so gpr_wire always reflects the
// architectural state as of the last committed instruction. The stream
// stops for good once an ebreak has been committed; only reset restarts it.
//
// Build option:
//   COMMIT_TRACE_MEM_EN  when defined, memory-access fields are stored per
//                        entry and driven on mem_*; otherwise wb_mem_* are
//                        ignored and mem_* are tied to 0.
//
// Handshake (writeback side): an event is taken on a rising clock edge
// where wb_valid && wb_ready. wb_ready depends only on block state (never
// on wb_valid); the producer must hold the event stable until it is taken.
// The sink side has no valid/ready pair: a commit happens on an edge where
// the FIFO is non-empty, dt_ready is high and the stream is not halted, and
// is announced by a one-cycle inst_commit pulse from registered outputs.
//
// Ports:
//   clock, reset           clock; synchronous active-low reset
//   wb_*                   retirement event from writeback, wb_ready back
//   dt_ready               sink can take a commit this cycle
//   inst_commit, commit_pc commit pulse and pc of committed instruction
//   gpr_wire               shadow GPR file, reg i at [XLEN*i +: XLEN]
//   cpu_ebreak_sign        pulse with the ebreak commit
//   mem_*                  memory-trace record of the committed instruction
//   commit_cnt             number of instructions committed (mod 2^64)
//   halted                 ebreak committed, stream stopped
//   dbg_state              stream-control state (0 run, 1 ebreak queued,
//                          2 halted)

module commit_trace_gen #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 64
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               wb_valid,
  output logic               wb_ready,
  input  logic [XLEN-1:0]    wb_pc,
  input  logic               wb_rd_wen,
  input  logic [4:0]         wb_rd_addr,
  input  logic [XLEN-1:0]    wb_rd_data,
  input  logic               wb_mem_req,
  input  logic               wb_mem_write,
  input  logic [XLEN-1:0]    wb_mem_addr,
  input  logic [XLEN-1:0]    wb_mem_data,
  input  logic [2:0]         wb_mem_size,
  input  logic               wb_ebreak,
  input  logic               dt_ready,
  output logic               inst_commit,
  output logic [XLEN-1:0]    commit_pc,
  output logic [XLEN*32-1:0] gpr_wire,
  output logic               cpu_ebreak_sign,
  output logic               mem_req,
  output logic               mem_write_read,
  output logic [XLEN-1:0]    mem_addr,
  output logic [XLEN-1:0]    mem_data,
  output logic [2:0]         mem_size,
  output logic [63:0]        commit_cnt,
  output logic               halted,
  output logic [1:0]         dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,  // accepting and draining
    ST_STOP_IN = 2'd1,  // ebreak enqueued, no further enqueues
    ST_HALTED  = 2'd2   // ebreak committed, nothing more drains
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // ---------------------------------------------------------------------
  // FIFO storage and pointers
  // ---------------------------------------------------------------------
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [XLEN-1:0]  r_pc_q     [DEPTH];
  logic             r_wen_q    [DEPTH];
  logic [4:0]       r_rd_q     [DEPTH];
  logic [XLEN-1:0]  r_data_q   [DEPTH];
  logic             r_ebreak_q [DEPTH];

  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_enq;
  logic             w_deq;
  logic             w_stop_in;
  logic             w_halted;

  logic [XLEN-1:0]  w_head_pc;
  logic             w_head_wen;
  logic [4:0]       w_head_rd;
  logic [XLEN-1:0]  w_head_data;
  logic             w_head_ebreak;

  assign w_wr_idx = r_wr_ptr[AW-1:0];
  assign w_rd_idx = r_rd_ptr[AW-1:0];

  // Extra wrap bit on each pointer disambiguates full from empty.
  assign w_full  = (w_wr_idx == w_rd_idx) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign wb_ready = !w_full && !w_stop_in;
  assign w_enq    = wb_valid && wb_ready;
  assign w_deq    = !w_empty && dt_ready && !w_halted;

  assign w_head_pc     = r_pc_q[w_rd_idx];
  assign w_head_wen    = r_wen_q[w_rd_idx];
  assign w_head_rd     = r_rd_q[w_rd_idx];
  assign w_head_data   = r_data_q[w_rd_idx];
  assign w_head_ebreak = r_ebreak_q[w_rd_idx];

  // Storage is not reset: entries are only meaningful between the pointers.
  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_pc_q[w_wr_idx]     <= wb_pc;
      r_wen_q[w_wr_idx]    <= wb_rd_wen;
      r_rd_q[w_wr_idx]     <= wb_rd_addr;
      r_data_q[w_wr_idx]   <= wb_rd_data;
      r_ebreak_q[w_wr_idx] <= wb_ebreak;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Stream-control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:     if (w_enq && wb_ebreak)        w_state_nxt = ST_STOP_IN;
      ST_STOP_IN: if (w_deq && w_head_ebreak)    w_state_nxt = ST_HALTED;
      ST_HALTED:                                 w_state_nxt = ST_HALTED;
      default:                                   w_state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    w_stop_in = (r_state != ST_RUN);
    w_halted  = (r_state == ST_HALTED);
  end

  assign halted    = w_halted;
  assign dbg_state = r_state;

  // ---------------------------------------------------------------------
  // Commit outputs
  // ---------------------------------------------------------------------
  logic            r_inst_commit;
  logic            r_ebreak_sign;
  logic [XLEN-1:0] r_commit_pc;
  logic [63:0]     r_commit_cnt;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_inst_commit <= 1'b0;
      r_ebreak_sign <= 1'b0;
      r_commit_pc   <= '0;
      r_commit_cnt  <= '0;
    end else begin
      r_inst_commit <= w_deq;
      r_ebreak_sign <= w_deq && w_head_ebreak;
      if (w_deq) begin
        r_commit_pc  <= w_head_pc;
        r_commit_cnt <= r_commit_cnt + 64'd1;
      end
    end
  end

  assign inst_commit     = r_inst_commit;
  assign cpu_ebreak_sign = r_ebreak_sign;
  assign commit_pc       = r_commit_pc;
  assign commit_cnt      = r_commit_cnt;

  // ---------------------------------------------------------------------
  // Shadow GPR file; x0 is only ever written by reset, so it reads 0.
  // ---------------------------------------------------------------------
  logic [XLEN-1:0] r_gpr [32];

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) r_gpr[i] <= '0;
    end else if (w_deq && w_head_wen && (w_head_rd != 5'd0)) begin
      r_gpr[w_head_rd] <= w_head_data;
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_gpr_wire
    assign gpr_wire[XLEN*g +: XLEN] = r_gpr[g];
  end

  // ---------------------------------------------------------------------
  // Memory-trace record
  // ---------------------------------------------------------------------
`ifdef COMMIT_TRACE_MEM_EN
  logic            r_mreq_q   [DEPTH];
  logic            r_mwr_q    [DEPTH];
  logic [XLEN-1:0] r_maddr_q  [DEPTH];
  logic [XLEN-1:0] r_mdata_q  [DEPTH];
  logic [2:0]      r_msize_q  [DEPTH];

  logic            r_mem_req;
  logic            r_mem_wr;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_mem_data;
  logic [2:0]      r_mem_size;

  always_ff @(posedge clock) begin
    if (w_enq) begin
      r_mreq_q[w_wr_idx]  <= wb_mem_req;
      r_mwr_q[w_wr_idx]   <= wb_mem_write;
      r_maddr_q[w_wr_idx] <= wb_mem_addr;
      r_mdata_q[w_wr_idx] <= wb_mem_data;
      r_msize_q[w_wr_idx] <= wb_mem_size;
    end
  end

  // mem_req is a pulse like inst_commit; the rest of the record holds.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_mem_req  <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_size <= '0;
    end else begin
      r_mem_req <= w_deq && r_mreq_q[w_rd_idx];
      if (w_deq) begin
        r_mem_wr   <= r_mwr_q[w_rd_idx];
        r_mem_addr <= r_maddr_q[w_rd_idx];
        r_mem_data <= r_mdata_q[w_rd_idx];
        r_mem_size <= r_msize_q[w_rd_idx];
      end
    end
  end

  assign mem_req        = r_mem_req;
  assign mem_write_read = r_mem_wr;
  assign mem_addr       = r_mem_addr;
  assign mem_data       = r_mem_data;
  assign mem_size       = r_mem_size;
`else
  logic w_unused_mem;
  assign w_unused_mem   = ^{wb_mem_req, wb_mem_write, wb_mem_addr,
                            wb_mem_data, wb_mem_size};

  assign mem_req        = 1'b0;
  assign mem_write_read = 1'b0;
  assign mem_addr       = '0;
  assign mem_data       = '0;
  assign mem_size       = '0;
`endif

endmodule

// File: tb/tb_commit_trace_gen.sv
module tb_commit_trace_gen;

  localparam int DEPTH = 4;
  localparam int XLEN  = 64;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic               wb_valid = 1'b0;
  logic               wb_ready;
  logic [XLEN-1:0]    wb_pc = '0;
  logic               wb_rd_wen = 1'b0;
  logic [4:0]         wb_rd_addr = '0;
  logic [XLEN-1:0]    wb_rd_data = '0;
  logic               wb_mem_req = 1'b0;
  logic               wb_mem_write = 1'b0;
  logic [XLEN-1:0]    wb_mem_addr = '0;
  logic [XLEN-1:0]    wb_mem_data = '0;
  logic [2:0]         wb_mem_size = '0;
  logic               wb_ebreak = 1'b0;
  logic               dt_ready = 1'b1;
  logic               inst_commit;
  logic [XLEN-1:0]    commit_pc;
  logic [XLEN*32-1:0] gpr_wire;
  logic               cpu_ebreak_sign;
  logic               mem_req;
  logic               mem_write_read;
  logic [XLEN-1:0]    mem_addr;
  logic [XLEN-1:0]    mem_data;
  logic [2:0]         mem_size;
  logic [63:0]        commit_cnt;
  logic               halted;
  logic [1:0]         dbg_state;

  commit_trace_gen #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_pc(wb_pc),
    .wb_rd_wen(wb_rd_wen), .wb_rd_addr(wb_rd_addr), .wb_rd_data(wb_rd_data),
    .wb_mem_req(wb_mem_req), .wb_mem_write(wb_mem_write),
    .wb_mem_addr(wb_mem_addr), .wb_mem_data(wb_mem_data),
    .wb_mem_size(wb_mem_size), .wb_ebreak(wb_ebreak), .dt_ready(dt_ready),
    .inst_commit(inst_commit), .commit_pc(commit_pc), .gpr_wire(gpr_wire),
    .cpu_ebreak_sign(cpu_ebreak_sign), .mem_req(mem_req),
    .mem_write_read(mem_write_read), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_size(mem_size), .commit_cnt(commit_cnt),
    .halted(halted), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] cnt;
    logic        ebreak;
    logic [4:0]  rd;
    logic [63:0] rd_val;
    logic        mreq;
    logic        mwr;
    logic [63:0] maddr;
    logic [63:0] mdata;
    logic [2:0]  msize;
  } exp_t;

  exp_t        exp_q[$];
  logic [63:0] model_gpr [32];
  logic [63:0] exp_cnt;
  int          n_checks = 0;
  int          n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_cnt = 64'd0;
    for (int i = 0; i < 32; i++) model_gpr[i] = 64'd0;
  endtask

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic apply_reset(input int cycles);
    @(posedge clock); #1;
    reset = 1'b0;
    model_clear();
    repeat (cycles) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  // Presents one event and holds it until taken; pushes the expected
  // commit record at acceptance.
  task automatic send(input logic [63:0] pc, input logic wen,
                      input logic [4:0] rd, input logic [63:0] data,
                      input logic mreq, input logic mwr,
                      input logic [63:0] maddr, input logic [63:0] mdata,
                      input logic [2:0] msize, input logic ebreak);
    int   waited;
    exp_t e;
    waited       = 0;
    wb_pc        = pc;
    wb_rd_wen    = wen;
    wb_rd_addr   = rd;
    wb_rd_data   = data;
    wb_mem_req   = mreq;
    wb_mem_write = mwr;
    wb_mem_addr  = maddr;
    wb_mem_data  = mdata;
    wb_mem_size  = msize;
    wb_ebreak    = ebreak;
    wb_valid     = 1'b1;
    @(negedge clock);
    while (wb_ready !== 1'b1 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (wb_ready !== 1'b1) begin
      chk("send_accept_timeout", {63'd0, wb_ready}, 64'd1);
      wb_valid = 1'b0;
      return;
    end
    if (wen && rd != 5'd0) model_gpr[rd] = data;
    exp_cnt   = exp_cnt + 64'd1;
    e.pc      = pc;
    e.cnt     = exp_cnt;
    e.ebreak  = ebreak;
    e.rd      = rd;
    e.rd_val  = model_gpr[rd];
`ifdef COMMIT_TRACE_MEM_EN
    e.mreq    = mreq;
    e.mwr     = mwr;
    e.maddr   = maddr;
    e.mdata   = mdata;
    e.msize   = msize;
`else
    e.mreq    = 1'b0;
    e.mwr     = 1'b0;
    e.maddr   = 64'd0;
    e.mdata   = 64'd0;
    e.msize   = 3'd0;
`endif
    exp_q.push_back(e);
    @(posedge clock); #1;
    wb_valid  = 1'b0;
    wb_ebreak = 1'b0;
  endtask

  task automatic send_alu(input logic [63:0] pc, input logic [4:0] rd,
                          input logic [63:0] data);
    send(pc, 1'b1, rd, data, 1'b0, 1'b0, 64'h0, 64'h0, 3'd0, 1'b0);
  endtask

  // Holds an event for several cycles expecting it never to be taken.
  task automatic expect_blocked(input logic [63:0] pc, input int cycles);
    logic seen_ready;
    seen_ready = 1'b0;
    wb_pc      = pc;
    wb_rd_wen  = 1'b1;
    wb_rd_addr = 5'd9;
    wb_rd_data = 64'hDEAD;
    wb_ebreak  = 1'b0;
    wb_valid   = 1'b1;
    repeat (cycles) begin
      @(negedge clock);
      if (wb_ready !== 1'b0) seen_ready = 1'b1;
    end
    @(posedge clock); #1;
    wb_valid = 1'b0;
    chk("blocked_after_ebreak", {63'd0, seen_ready}, 64'd0);
  endtask

  task automatic wait_drain();
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    chk("drain_pending", exp_q.size(), 64'd0);
  endtask

  // ---------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------
  always @(negedge clock) begin
    exp_t e;
    if (inst_commit === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit_pc", commit_pc, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("commit_pc", commit_pc, e.pc);
        chk("commit_cnt", commit_cnt, e.cnt);
        chk("ebreak_sign", {63'd0, cpu_ebreak_sign}, {63'd0, e.ebreak});
        chk("gpr_rd", gpr_wire[XLEN*e.rd +: XLEN], e.rd_val);
        chk("gpr_x0", gpr_wire[XLEN-1:0], 64'd0);
        chk("mem_req", {63'd0, mem_req}, {63'd0, e.mreq});
        chk("mem_write_read", {63'd0, mem_write_read}, {63'd0, e.mwr});
        chk("mem_addr", mem_addr, e.maddr);
        chk("mem_data", mem_data, e.mdata);
        chk("mem_size", {61'd0, mem_size}, {61'd0, e.msize});
      end
    end else if (inst_commit === 1'b0) begin
      chk("idle_ebreak_sign", {63'd0, cpu_ebreak_sign}, 64'd0);
      chk("idle_mem_req", {63'd0, mem_req}, 64'd0);
    end
  end

  // ---------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------
  initial begin
    model_clear();
    apply_reset(3);

    // Reset state
    @(negedge clock);
    chk("rst_inst_commit", {63'd0, inst_commit}, 64'd0);
    chk("rst_commit_cnt", commit_cnt, 64'd0);
    chk("rst_commit_pc", commit_pc, 64'd0);
    chk("rst_halted", {63'd0, halted}, 64'd0);
    chk("rst_wb_ready", {63'd0, wb_ready}, 64'd1);
    chk("rst_gpr_zero", {63'd0, (gpr_wire == '0)}, 64'd1);
    @(posedge clock); #1;

    // Single event, one-cycle latency after acceptance edge
    send_alu(64'h8000_0000, 5'd5, 64'h1234);
    @(negedge clock);
    chk("lat_not_yet", {63'd0, inst_commit}, 64'd0);
    @(negedge clock);
    chk("lat_commit", {63'd0, inst_commit}, 64'd1);
    chk("lat_reg5", gpr_wire[XLEN*5 +: XLEN], 64'h1234);
    chk("lat_cnt", commit_cnt, 64'd1);
    @(posedge clock); #1;

    // Write to x0 is dropped
    send_alu(64'h8000_0004, 5'd0, 64'hFFFF);
    wait_drain();
    @(negedge clock);
    chk("x0_stays_zero", gpr_wire[XLEN-1:0], 64'd0);
    chk("reg5_holds", gpr_wire[XLEN*5 +: XLEN], 64'h1234);
    @(posedge clock); #1;

    // Fill with sink stalled, then drain back-to-back
    dt_ready = 1'b0;
    send_alu(64'h8000_0010, 5'd1, 64'h11);
    send_alu(64'h8000_0014, 5'd2, 64'h22);
    send_alu(64'h8000_0018, 5'd1, 64'h33);
    send_alu(64'h8000_001C, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
    @(negedge clock);
    chk("full_wb_ready", {63'd0, wb_ready}, 64'd0);
    chk("full_no_commit", {63'd0, inst_commit}, 64'd0);
    dt_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk("burst_commit", {63'd0, inst_commit}, 64'd1);
    end
    chk("ready_after_drain", {63'd0, wb_ready}, 64'd1);
    @(negedge clock);
    chk("burst_end", {63'd0, inst_commit}, 64'd0);
    chk("burst_cnt", commit_cnt, 64'd6);
    @(posedge clock); #1;

    // Memory-trace records: store, then load
    send(64'h8000_0020, 1'b0, 5'd0, 64'h0, 1'b1, 1'b1,
         64'h8000_1000, 64'hAB, 3'd0, 1'b0);
    send(64'h8000_0024, 1'b1, 5'd7, 64'h55, 1'b1, 1'b0,
         64'h8000_2000, 64'h55, 3'd3, 1'b0);
    wait_drain();
    @(posedge clock); #1;

    // Ebreak: commit pulse, halt, block further events
    send(64'h8000_0100, 1'b0, 5'd0, 64'h0, 1'b0, 1'b0,
         64'h0, 64'h0, 3'd0, 1'b1);
    expect_blocked(64'h8000_0104, 8);
    wait_drain();
    @(negedge clock);
    chk("halted_set", {63'd0, halted}, 64'd1);
    chk("halted_wb_ready", {63'd0, wb_ready}, 64'd0);
    chk("halted_cnt", commit_cnt, 64'd9);

    // Reset with entries buffered: nothing drains
    apply_reset(2);
    dt_ready = 1'b0;
    send_alu(64'h8000_0200, 5'd3, 64'hA);
    send_alu(64'h8000_0204, 5'd4, 64'hB);
    send_alu(64'h8000_0208, 5'd6, 64'hC);
    apply_reset(1);
    dt_ready = 1'b1;
    repeat (5) @(negedge clock);
    chk("rst2_commit_cnt", commit_cnt, 64'd0);
    chk("rst2_gpr_zero", {63'd0, (gpr_wire == '0)}, 64'd1);
    chk("rst2_wb_ready", {63'd0, wb_ready}, 64'd1);
    chk("rst2_halted", {63'd0, halted}, 64'd0);
    @(posedge clock); #1;

    // Stream resumes after reset
    send_alu(64'h8000_0300, 5'd10, 64'h0BAD_F00D);
    wait_drain();
    @(negedge clock);
    chk("resume_cnt", commit_cnt, 64'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    n_errors++;
    $display("FAIL global_timeout actual=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule
